// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge-magnitude filter, one 8-bit pixel in and one out per accepted pixel.
// Two line buffers plus a two-column window history feed a registered |Gx|+|Gy| output.
module sobel_edge_filter #(
   parameter int WIDTH_P  = 640,
   parameter int HEIGHT_P = 480
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       valid_i,
   input  logic [7:0] pixel_i,
   output logic       valid_o,
   output logic [7:0] pixel_o
);

   localparam int CW = (WIDTH_P  > 1) ? $clog2(WIDTH_P)  : 1;
   localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
   localparam int FW = $clog2(WIDTH_P + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH_P - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT_P - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH_P);
   localparam logic [CW-1:0] COL_ONE    = CW'(1);
   localparam logic [RW-1:0] ROW_ONE    = RW'(1);
   localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

   typedef enum logic [0:0] {
      ST_STREAM = 1'b0,
      ST_FLUSH  = 1'b1
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] col_r, col_s;
   logic [RW-1:0] row_r, row_s;
   logic [FW-1:0] flush_cnt_r, flush_cnt_s;

   logic [7:0] lb_top_r [0:WIDTH_P-1];
   logic [7:0] lb_mid_r [0:WIDTH_P-1];

   logic [7:0] w1_top_r, w1_mid_r, w1_bot_r;
   logic [7:0] w2_top_r, w2_mid_r, w2_bot_r;
   logic [7:0] cur_top_s, cur_mid_s;

   logic       accept_s;
   logic       out_en_s;
   logic       border_s;
   logic [9:0] gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
   logic [9:0] gx_abs_s, gy_abs_s;
   logic [11:0] mag_sum_s;
   logic [7:0] mag_sat_s;

   function automatic logic [9:0] sum_121(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
      sum_121 = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

   assign accept_s = (state_r == ST_STREAM) && valid_i;

   // State and position counters.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r     <= ST_STREAM;
         col_r       <= '0;
         row_r       <= '0;
         flush_cnt_r <= '0;
      end else begin
         state_r     <= state_s;
         col_r       <= col_s;
         row_r       <= row_s;
         flush_cnt_r <= flush_cnt_s;
      end
   end

   // Next-state: raster walk while streaming, fixed-length drain after the last pixel.
   always_comb begin
      state_s     = state_r;
      col_s       = col_r;
      row_s       = row_r;
      flush_cnt_s = flush_cnt_r;
      case (state_r)
         ST_STREAM: begin
            if (valid_i) begin
               if (col_r == COL_LAST) begin
                  col_s = '0;
                  if (row_r == ROW_LAST) begin
                     row_s       = '0;
                     flush_cnt_s = '0;
                     state_s     = ST_FLUSH;
                  end else begin
                     row_s = row_r + ROW_ONE;
                  end
               end else begin
                  col_s = col_r + COL_ONE;
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) begin
               flush_cnt_s = '0;
               state_s     = ST_STREAM;
            end else begin
               flush_cnt_s = flush_cnt_r + FLUSH_ONE;
            end
         end
         default: begin
            state_s     = ST_STREAM;
            col_s       = '0;
            row_s       = '0;
            flush_cnt_s = '0;
         end
      endcase
   end

   // Line buffers: top holds row r-2, mid holds row r-1 at the current column.
   always_ff @(posedge clk_i) begin
      if (accept_s) begin
         lb_top_r[col_r] <= lb_mid_r[col_r];
         lb_mid_r[col_r] <= pixel_i;
      end else begin
         lb_top_r[col_r] <= lb_top_r[col_r];
      end
   end

   assign cur_top_s = lb_top_r[col_r];
   assign cur_mid_s = lb_mid_r[col_r];

   // Window history: w1 is column c-1, w2 is column c-2 of the same three rows.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         w1_top_r <= 8'h00;
         w1_mid_r <= 8'h00;
         w1_bot_r <= 8'h00;
         w2_top_r <= 8'h00;
         w2_mid_r <= 8'h00;
         w2_bot_r <= 8'h00;
      end else if (accept_s) begin
         w1_top_r <= cur_top_s;
         w1_mid_r <= cur_mid_s;
         w1_bot_r <= pixel_i;
         w2_top_r <= w1_top_r;
         w2_mid_r <= w1_mid_r;
         w2_bot_r <= w1_bot_r;
      end else begin
         w1_top_r <= w1_top_r;
         w2_top_r <= w2_top_r;
      end
   end

   // Centre is (row-1, col-1); col 0/1 put the centre on a column edge, row 1 on the top edge.
   always_comb begin
      out_en_s = (row_r != '0) && !((row_r == ROW_ONE) && (col_r == '0));
      border_s = (col_r == '0) || (col_r == COL_ONE) || (row_r == ROW_ONE);
   end

   // Gradient magnitude; stale window data only ever reaches border centres, which are forced to zero.
   always_comb begin
      gx_pos_s  = sum_121(cur_top_s, cur_mid_s, pixel_i);
      gx_neg_s  = sum_121(w2_top_r,  w2_mid_r,  w2_bot_r);
      gy_pos_s  = sum_121(w2_bot_r,  w1_bot_r,  pixel_i);
      gy_neg_s  = sum_121(w2_top_r,  w1_top_r,  cur_top_s);
      gx_abs_s  = abs_diff(gx_pos_s, gx_neg_s);
      gy_abs_s  = abs_diff(gy_pos_s, gy_neg_s);
      mag_sum_s = {2'b00, gx_abs_s} + {2'b00, gy_abs_s};
      if (mag_sum_s[11:8] != 4'h0) begin
         mag_sat_s = 8'hFF;
      end else begin
         mag_sat_s = mag_sum_s[7:0];
      end
   end

   // Registered output stage.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         valid_o <= 1'b0;
         pixel_o <= 8'h00;
      end else begin
         case (state_r)
            ST_STREAM: begin
               if (valid_i && out_en_s) begin
                  valid_o <= 1'b1;
                  pixel_o <= border_s ? 8'h00 : mag_sat_s;
               end else begin
                  valid_o <= 1'b0;
                  pixel_o <= 8'h00;
               end
            end
            ST_FLUSH: begin
               valid_o <= 1'b1;
               pixel_o <= 8'h00;
            end
            default: begin
               valid_o <= 1'b0;
               pixel_o <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter on an 8x6 frame: a reference model pushes the
// expected magnitude for each driven pixel, and a negedge monitor pops and compares.
module tb_sobel_edge_filter;

   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       valid_i;
   logic [7:0] pixel_i;
   logic       valid_o;
   logic [7:0] pixel_o;

   int frm [0:H-1][0:W-1];
   int exp_q [$];
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int out_cnt = 0;
   int first_valid_cyc = -1;
   int last_valid_cyc  = 0;
   int last_accept_cyc = 0;
   int acc9_cyc        = 0;

   sobel_edge_filter #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .pixel_i (pixel_i),
      .valid_o (valid_o),
      .pixel_o (pixel_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_pix(input int j);
      int r = j / W;
      int c = j % W;
      int gx, gy, s;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
      gx = (frm[r-1][c+1] + 2*frm[r][c+1] + frm[r+1][c+1])
         - (frm[r-1][c-1] + 2*frm[r][c-1] + frm[r+1][c-1]);
      gy = (frm[r+1][c-1] + 2*frm[r+1][c] + frm[r+1][c+1])
         - (frm[r-1][c-1] + 2*frm[r-1][c] + frm[r-1][c+1]);
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (s > 255) ? 255 : s;
   endfunction

   // kind 0: uniform val, 1: vertical step, 2: horizontal ramp 10*c
   task automatic fill_frame(input int kind, input int val);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (kind)
               1:       frm[r][c] = (c < 4) ? 0 : 255;
               2:       frm[r][c] = 10 * c;
               default: frm[r][c] = val;
            endcase
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send_px(input int k);
      valid_i = 1'b1;
      pixel_i = 8'(frm[k / W][k % W]);
      if (k >= W + 1) exp_q.push_back(exp_pix(k - W - 1));
      if (k == N - 1)
         for (int i = N - W - 1; i < N; i++) exp_q.push_back(exp_pix(i));
      @(posedge clk_i);
      #1;
      last_accept_cyc = cyc;
      if (k == W + 1) acc9_cyc = cyc;
      valid_i = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int val, input bit gaps);
      fill_frame(kind, val);
      for (int k = 0; k < N; k++) begin
         if (gaps)
            while ($urandom_range(0, 2) == 0) idle(1);
         send_px(k);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
      check_val("drain", exp_q.size(), 0);
      idle(3);
   endtask

   task automatic new_frame_stats();
      out_cnt = 0;
      first_valid_cyc = -1;
   endtask

   initial begin : monitor
      int e;
      forever begin
         @(negedge clk_i);
         if (valid_o === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            out_cnt++;
            if (exp_q.size() == 0) begin
               check_val("extra_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("pix", int'(pixel_o), e);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b0;
      valid_i = 1'b0;
      pixel_i = 8'h00;
      repeat (3) @(posedge clk_i);
      #1;
      check_val("rst_valid", int'(valid_o), 0);
      check_val("rst_pixel", int'(pixel_o), 0);
      reset_i = 1'b1;
      idle(2);

      // uniform 0x80
      new_frame_stats();
      send_frame(0, 8'h80, 1'b0);
      drain();
      check_val("t1_count", out_cnt, N);
      check_val("t1_first", first_valid_cyc, acc9_cyc);
      check_val("t1_last", last_valid_cyc - last_accept_cyc, W + 1);

      // vertical step
      new_frame_stats();
      send_frame(1, 0, 1'b0);
      drain();
      check_val("t2_count", out_cnt, N);

      // horizontal ramp
      new_frame_stats();
      send_frame(2, 0, 1'b0);
      drain();
      check_val("t3_count", out_cnt, N);

      // vertical step with random valid gaps
      new_frame_stats();
      send_frame(1, 0, 1'b1);
      drain();
      check_val("t4_count", out_cnt, N);
      check_val("t4_last", last_valid_cyc - last_accept_cyc, W + 1);

      // reset mid-frame, then a clean zero frame
      fill_frame(0, 8'h55);
      for (int k = 0; k < 20; k++) send_px(k);
      #2;
      reset_i = 1'b0;
      #1;
      check_val("t5_async_valid", int'(valid_o), 0);
      check_val("t5_async_pixel", int'(pixel_o), 0);
      exp_q.delete();
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      idle(1);
      new_frame_stats();
      send_frame(0, 0, 1'b0);
      drain();
      check_val("t5_count", out_cnt, N);

      // back-to-back frames with the minimum idle gap
      new_frame_stats();
      send_frame(2, 0, 1'b0);
      idle(W + 1);
      send_frame(1, 0, 1'b0);
      drain();
      check_val("t6_count", out_cnt, 2 * N);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
